// File: rtl/timer_multi_top_if.sv
// OBI peripheral slot for the multi-channel timer: request/write-data bus in, read data and interrupts out.
// Handshake: there is no gnt; every req_i cycle is accepted, a read returns data_o on the following cycle and data_o holds until the next read.
interface timer_multi_top_if #(
    parameter int NUM_CH = 4
);
    logic              req_i;
    logic              we_i;
    logic [3:0]        be_i;
    logic [31:0]       addr_i;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic              irq_o;
    logic [NUM_CH-1:0] irq_ch_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, data_i,
        output data_o, irq_o, irq_ch_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, data_i,
        input  data_o, irq_o, irq_ch_o
    );
endinterface

// File: rtl/timer_multi_top.sv
// NUM_CH independent down-counting timers with 8-bit prescalers, one-shot/periodic modes
// and sticky per-channel pending bits, combined into a single interrupt line.
module timer_multi_top #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    timer_multi_top_if.slave bus
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_VALUE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [NUM_CH-1:0]            en;
    logic [NUM_CH-1:0]            mode;
    logic [NUM_CH-1:0]            ie;
    logic [NUM_CH-1:0]            pend;
    logic [NUM_CH-1:0][7:0]       presc;
    logic [NUM_CH-1:0][7:0]       pcnt;
    logic [NUM_CH-1:0][CNT_W-1:0] load;
    logic [NUM_CH-1:0][CNT_W-1:0] value;
    logic [31:0]                  data_q;

    logic [15:0]       addr;
    logic [2:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              ch_hit;
    logic              irqs_hit;
    logic              wr;
    logic [NUM_CH-1:0] sel;
    logic [31:0]       be_mask;
    logic [31:0]       ctrl_cur;
    logic [31:0]       load_cur;
    logic [31:0]       value_cur;
    logic [31:0]       status_cur;
    logic [31:0]       rdata;
    logic [31:0]       wr_ctrl;
    logic [31:0]       wr_load;
    logic              clr_pend;
    logic              unused_bits;

    assign addr     = bus.addr_i[15:0];
    assign ch_sel   = addr[6:4];
    assign reg_sel  = addr[3:2];
    assign ch_hit   = (addr[15:7] == 9'd0) && (addr[1:0] == 2'd0) && ({29'd0, ch_sel} < 32'(NUM_CH));
    assign irqs_hit = (addr == 16'h0100);
    assign wr       = bus.req_i && bus.we_i;
    assign be_mask  = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
    assign clr_pend = wr && (reg_sel == REG_STATUS) && bus.be_i[0] && bus.data_i[0];

    always_comb begin
        sel        = '0;
        ctrl_cur   = '0;
        load_cur   = '0;
        value_cur  = '0;
        status_cur = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit && ({29'd0, ch_sel} == 32'(i))) begin
                sel[i]     = 1'b1;
                ctrl_cur   = {16'd0, presc[i], 5'd0, ie[i], mode[i], en[i]};
                load_cur   = 32'(load[i]);
                value_cur  = 32'(value[i]);
                status_cur = {31'd0, pend[i]};
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (irqs_hit) begin
            rdata = 32'(pend);
        end else if (ch_hit) begin
            case (reg_sel)
                REG_CTRL:  rdata = ctrl_cur;
                REG_LOAD:  rdata = load_cur;
                REG_VALUE: rdata = value_cur;
                default:   rdata = status_cur;
            endcase
        end
    end

    // Byte-enable merge against the addressed channel's current register contents.
    assign wr_ctrl = (ctrl_cur & ~be_mask) | (bus.data_i & be_mask);
    assign wr_load = (load_cur & ~be_mask) | (bus.data_i & be_mask);

    // Statement order sets same-cycle priority: W1C < expiry set, hardware EN clear < CTRL write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en     <= '0;
            mode   <= '0;
            ie     <= '0;
            pend   <= '0;
            presc  <= '0;
            pcnt   <= '0;
            load   <= '0;
            value  <= '0;
            data_q <= '0;
        end else begin
            if (bus.req_i && !bus.we_i) begin
                data_q <= rdata;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_pend && sel[i]) begin
                    pend[i] <= 1'b0;
                end
                if (en[i]) begin
                    if (pcnt[i] == presc[i]) begin
                        pcnt[i] <= 8'd0;
                        if (value[i] != '0) begin
                            value[i] <= value[i] - CNT_W'(1);
                        end else begin
                            pend[i] <= 1'b1;
                            if (mode[i]) begin
                                value[i] <= load[i];
                            end else begin
                                en[i] <= 1'b0;
                            end
                        end
                    end else begin
                        pcnt[i] <= pcnt[i] + 8'd1;
                    end
                end
                if (wr && sel[i] && (reg_sel == REG_CTRL)) begin
                    en[i]    <= wr_ctrl[0];
                    mode[i]  <= wr_ctrl[1];
                    ie[i]    <= wr_ctrl[2];
                    presc[i] <= wr_ctrl[15:8];
                    if (!en[i] && wr_ctrl[0]) begin
                        value[i] <= load[i];
                        pcnt[i]  <= 8'd0;
                    end
                end
                if (wr && sel[i] && (reg_sel == REG_LOAD)) begin
                    load[i] <= wr_load[CNT_W-1:0];
                end
            end
        end
    end

    assign bus.data_o   = data_q;
    assign bus.irq_ch_o = pend & ie;
    assign bus.irq_o    = |(pend & ie);

    assign unused_bits = ^{bus.addr_i[31:16], wr_ctrl, wr_load};
endmodule
